// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Each instruction is walked through fetch, decode, execute, memory and
// writeback. Datapath enables are a Moore decode of the state and are held
// in flops that load the decode of the next state, so they always match o_state.
//
// state        | meaning
// -------------+-------------------------------------------------------
// FETCH   (0)  | read instruction, load IR, PC <= PC + 4
// DECODE  (1)  | branch target into ALUOut, dispatch on opcode
// MEMADR  (2)  | effective address = A + sign-extended immediate
// MEMRD   (3)  | read data memory at ALUOut
// MEMWB   (4)  | write MDR into rt
// MEMWR   (5)  | write B to data memory at ALUOut
// EXEC    (6)  | R-type ALU operation on A, B
// ALUWB   (7)  | write ALUOut into rd
// BRANCH  (8)  | compare A, B; PC <= ALUOut if equal
// JUMP    (9)  | PC <= jump target
// ADDIEX  (10) | A + sign-extended immediate
// ADDIWB  (11) | write ALUOut into rt
// 12..15       | unreachable; outputs zero, return to FETCH

module mips_multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  output logic       o_pcWrite,
  output logic       o_pcWriteCond,
  output logic       o_iorD,
  output logic       o_memRead,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_memToReg,
  output logic       o_regDst,
  output logic       o_regWrite,
  output logic       o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_aluOp,
  output logic [1:0] o_pcSource,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Control point values for a given state; anything not set stays 0.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
        c.pc_write  = 1'b1;
        c.pc_source = 2'b00;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = 2'b00;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b00;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = 2'b00;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection; opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (i_opcode == OP_LW || i_opcode == OP_SW) state_d = S_MEMADR;
        else if (i_opcode == OP_RTYPE)               state_d = S_EXEC;
        else if (i_opcode == OP_BEQ)                 state_d = S_BRANCH;
        else if (i_opcode == OP_J)                   state_d = S_JUMP;
        else if (i_opcode == OP_ADDI)                state_d = S_ADDIEX;
        else                                         state_d = S_FETCH;
      end
      S_MEMADR: begin
        // Opcode is stable here; anything other than lw/sw is abandoned.
        if (i_opcode == OP_LW)      state_d = S_MEMRD;
        else if (i_opcode == OP_SW) state_d = S_MEMWR;
        else                        state_d = S_FETCH;
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are loaded with the decode of the state being entered.
  always_comb begin
    ctrl_d = decode_ctrl(state_d);
  end

  // State and output registers; reset lands in FETCH with its outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign o_pcWrite     = ctrl_q.pc_write;
  assign o_pcWriteCond = ctrl_q.pc_write_cond;
  assign o_iorD        = ctrl_q.ior_d;
  assign o_memRead     = ctrl_q.mem_read;
  assign o_memWrite    = ctrl_q.mem_write;
  assign o_irWrite     = ctrl_q.ir_write;
  assign o_memToReg    = ctrl_q.mem_to_reg;
  assign o_regDst      = ctrl_q.reg_dst;
  assign o_regWrite    = ctrl_q.reg_write;
  assign o_aluSrcA     = ctrl_q.alu_src_a;
  assign o_aluSrcB     = ctrl_q.alu_src_b;
  assign o_aluOp       = ctrl_q.alu_op;
  assign o_pcSource    = ctrl_q.pc_source;
  assign o_state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control.
// The driver plays whole instructions, pushing the state and control word it
// expects each cycle; the monitor pops and compares on every falling edge.

module tb_mips_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic       i_clk;
  logic       i_rst;
  logic [5:0] i_opcode;
  logic       o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite, o_irWrite;
  logic       o_memToReg, o_regDst, o_regWrite, o_aluSrcA;
  logic [1:0] o_aluSrcB, o_aluOp, o_pcSource;
  logic [3:0] o_state;

  mips_multicycle_control dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode),
    .o_pcWrite(o_pcWrite), .o_pcWriteCond(o_pcWriteCond), .o_iorD(o_iorD),
    .o_memRead(o_memRead), .o_memWrite(o_memWrite), .o_irWrite(o_irWrite),
    .o_memToReg(o_memToReg), .o_regDst(o_regDst), .o_regWrite(o_regWrite),
    .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_aluOp(o_aluOp),
    .o_pcSource(o_pcSource), .o_state(o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  typedef struct {
    int         tag;
    logic [3:0] state;
    ctrl_t      ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference: control word expected in each named state of the instruction flow.
  function automatic ctrl_t ref_ctrl(input int s);
    ctrl_t c;
    c = '0;
    case (s)
      0:  begin c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_write = 1; end
      1:  begin c.alu_src_b = 2'b11; end
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.ior_d = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.ior_d = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: begin c.reg_write = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Push one cycle: inputs set now are consumed at the next rising edge,
  // whose result is sampled two falling edges from now.
  task automatic step(input logic rst, input logic [5:0] op, input int exp_state);
    exp_t e;
    @(posedge i_clk);
    #1;
    i_rst    = rst;
    i_opcode = op;
    e.tag   = cyc + 2;
    e.state = 4'(exp_state);
    e.ctrl  = ref_ctrl(exp_state);
    exp_q.push_back(e);
  endtask

  // Whole instruction from FETCH; abort_at >= 0 replaces that step with reset.
  task automatic run_instr(input logic [5:0] op, input int abort_at);
    int seq[$];
    case (op)
      OP_LW:    seq = '{1, 2, 3, 4, 0};
      OP_SW:    seq = '{1, 2, 5, 0};
      OP_RTYPE: seq = '{1, 6, 7, 0};
      OP_ADDI:  seq = '{1, 10, 11, 0};
      OP_BEQ:   seq = '{1, 8, 0};
      OP_J:     seq = '{1, 9, 0};
      default:  seq = '{1, 0};
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        step(1'b1, op, 0);
        step(1'b0, op, 1);
        seq = '{2, 3, 4, 0};
        if (op == OP_LW) begin
          for (int j = 0; j < seq.size(); j++) step(1'b0, op, seq[j]);
        end
        return;
      end
      step(1'b0, op, seq[i]);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction

  // Monitor: compare whenever the front of the scoreboard is due this cycle.
  always @(negedge i_clk) begin
    ctrl_t act;
    exp_t  e;
    cyc = cyc + 1;
    act = {o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite, o_irWrite,
           o_memToReg, o_regDst, o_regWrite, o_aluSrcA, o_aluSrcB, o_aluOp, o_pcSource};
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (o_state !== e.state) begin
        errors = errors + 1;
        $display("FAIL state cyc=%0d actual=%0d required=%0d", cyc, o_state, e.state);
      end
      checks = checks + 1;
      if (act !== e.ctrl) begin
        errors = errors + 1;
        $display("FAIL ctrl cyc=%0d state=%0d actual=%h required=%h", cyc, e.state, act, e.ctrl);
      end
      checks = checks + 1;
      if (o_aluOp === 2'b11 || (o_memRead === 1'b1 && o_memWrite === 1'b1)) begin
        errors = errors + 1;
        $display("FAIL invariant cyc=%0d actual aluOp=%b memRead=%b memWrite=%b required aluOp!=11 and not both", cyc, o_aluOp, o_memRead, o_memWrite);
      end
    end
  end

  initial begin
    logic [5:0] op;
    logic [5:0] legal[6];
    legal = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    i_rst    = 1'b1;
    i_opcode = 6'($urandom);

    step(1'b1, 6'($urandom), 0);
    step(1'b1, 6'($urandom), 0);

    run_instr(OP_LW, -1);
    run_instr(OP_RTYPE, -1);
    run_instr(OP_BEQ, -1);
    run_instr(OP_J, -1);
    run_instr(OP_SW, -1);
    run_instr(OP_ADDI, -1);
    run_instr(6'b111111, -1);
    // reset while in MEMRD: the step that would enter MEMWB is replaced by reset
    run_instr(OP_LW, 3);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal[$urandom_range(0, 5)];
      end
      if (op == OP_LW && $urandom_range(0, 5) == 0)
        run_instr(op, 3);
      else
        run_instr(op, -1);
    end

    repeat (4) @(negedge i_clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
